// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcode constants and the sequencer state type.
// Used by the control sequencer, its ring counter and the IR bench.
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_T1   = 3'd0,
      ST_T2   = 3'd1,
      ST_T3   = 3'd2,
      ST_T4   = 3'd3,
      ST_T5   = 3'd4,
      ST_T6   = 3'd5,
      ST_HALT = 3'd6
   } state_t;

endpackage

// File: rtl/ring_counter.sv
// T-state sequencer: T1..T6 ring with a terminal HALT state.
// tstate is one-hot (bit0 = T1) and all-zero while halted.
module ring_counter
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       halt,
   output logic [5:0] tstate
);

   state_t state_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_T1;
      end else if (halt) begin
         state_reg <= ST_HALT;
      end else begin
         case (state_reg)
            ST_T1:   state_reg <= ST_T2;
            ST_T2:   state_reg <= ST_T3;
            ST_T3:   state_reg <= ST_T4;
            ST_T4:   state_reg <= ST_T5;
            ST_T5:   state_reg <= ST_T6;
            ST_T6:   state_reg <= ST_T1;
            default: state_reg <= ST_HALT;
         endcase
      end
   end

   // HALT has no matching bit, so every tstate bit drops to zero there.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_onehot
         assign tstate[gi] = (state_reg == state_t'(3'(gi)));
      end
   endgenerate

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: combinational control-word decode of T-state and opcode.
// Optional macro SAP_JMP_EN enables the JMP (4'h6) instruction; otherwise pc_load is 0.
module control_sequencer
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   output logic [5:0] tstate,
   output logic       pc_inc,
   output logic       pc_out,
   output logic       pc_load,
   output logic       mar_load,
   output logic       ram_out,
   output logic       ir_load,
   output logic       ir_out,
   output logic       a_load,
   output logic       a_out,
   output logic       b_load,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       out_load,
   output logic       halted
);

   logic halt_req;

   // HLT is recognised in T4 so the halt takes effect at the T4->T5 edge.
   assign halt_req = tstate[3] && (opcode == OP_HLT);

   ring_counter u_ring (
      .clk    (clk),
      .reset  (reset),
      .halt   (halt_req),
      .tstate (tstate)
   );

   assign halted = (tstate == 6'b000000);

   always_comb begin
      pc_inc   = 1'b0;
      pc_out   = 1'b0;
      pc_load  = 1'b0;
      mar_load = 1'b0;
      ram_out  = 1'b0;
      ir_load  = 1'b0;
      ir_out   = 1'b0;
      a_load   = 1'b0;
      a_out    = 1'b0;
      b_load   = 1'b0;
      alu_out  = 1'b0;
      alu_sub  = 1'b0;
      out_load = 1'b0;

      if (tstate[0]) begin
         pc_out   = 1'b1;
         mar_load = 1'b1;
      end
      if (tstate[1]) begin
         pc_inc = 1'b1;
      end
      if (tstate[2]) begin
         ram_out = 1'b1;
         ir_load = 1'b1;
      end
      if (tstate[3]) begin
         case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
               ir_out   = 1'b1;
               mar_load = 1'b1;
            end
            OP_OUT: begin
               a_out    = 1'b1;
               out_load = 1'b1;
            end
`ifdef SAP_JMP_EN
            OP_JMP: begin
               ir_out  = 1'b1;
               pc_load = 1'b1;
            end
`endif
            default: ;
         endcase
      end
      if (tstate[4]) begin
         case (opcode)
            OP_LDA: begin
               ram_out = 1'b1;
               a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               ram_out = 1'b1;
               b_load  = 1'b1;
            end
            default: ;
         endcase
      end
      if (tstate[5]) begin
         case (opcode)
            OP_ADD: begin
               alu_out = 1'b1;
               a_load  = 1'b1;
            end
            OP_SUB: begin
               alu_out = 1'b1;
               alu_sub = 1'b1;
               a_load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed control words per T-state.
// Expectations for opcode 4'h6 follow the SAP_JMP_EN build setting.
`timescale 1ns/1ps
module tb_control_sequencer;

   localparam logic [12:0] C_NONE     = 13'd0;
   localparam logic [12:0] C_PC_INC   = 13'd1 << 12;
   localparam logic [12:0] C_PC_OUT   = 13'd1 << 11;
   localparam logic [12:0] C_PC_LOAD  = 13'd1 << 10;
   localparam logic [12:0] C_MAR_LOAD = 13'd1 << 9;
   localparam logic [12:0] C_RAM_OUT  = 13'd1 << 8;
   localparam logic [12:0] C_IR_LOAD  = 13'd1 << 7;
   localparam logic [12:0] C_IR_OUT   = 13'd1 << 6;
   localparam logic [12:0] C_A_LOAD   = 13'd1 << 5;
   localparam logic [12:0] C_A_OUT    = 13'd1 << 4;
   localparam logic [12:0] C_B_LOAD   = 13'd1 << 3;
   localparam logic [12:0] C_ALU_OUT  = 13'd1 << 2;
   localparam logic [12:0] C_ALU_SUB  = 13'd1 << 1;
   localparam logic [12:0] C_OUT_LOAD = 13'd1 << 0;

   localparam logic [12:0] W_T1 = C_PC_OUT | C_MAR_LOAD;
   localparam logic [12:0] W_T2 = C_PC_INC;
   localparam logic [12:0] W_T3 = C_RAM_OUT | C_IR_LOAD;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic [5:0] tstate;
   logic       pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out;
   logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
   logic [12:0] ctl;
   int checks = 0;
   int errors = 0;

   control_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .tstate   (tstate),
      .pc_inc   (pc_inc),
      .pc_out   (pc_out),
      .pc_load  (pc_load),
      .mar_load (mar_load),
      .ram_out  (ram_out),
      .ir_load  (ir_load),
      .ir_out   (ir_out),
      .a_load   (a_load),
      .a_out    (a_out),
      .b_load   (b_load),
      .alu_out  (alu_out),
      .alu_sub  (alu_sub),
      .out_load (out_load),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out, alu_sub, out_load};

   task automatic check_now(input string tag, input logic [5:0] exp_t,
                            input logic [12:0] exp_c, input logic exp_h);
      logic [2:0] drivers;
      drivers = 3'(pc_out) + 3'(ram_out) + 3'(ir_out) + 3'(a_out) + 3'(alu_out);
      $display("step %s: tstate=%02h ctl=%04h halted=%0b", tag, tstate, ctl, halted);
      checks++;
      assert (tstate === exp_t) else begin
         errors++;
         $error("FAIL %s tstate got %02h want %02h", tag, tstate, exp_t);
      end
      checks++;
      assert (ctl === exp_c) else begin
         errors++;
         $error("FAIL %s ctl got %04h want %04h", tag, ctl, exp_c);
      end
      checks++;
      assert (halted === exp_h) else begin
         errors++;
         $error("FAIL %s halted got %0b want %0b", tag, halted, exp_h);
      end
      checks++;
      assert ((drivers <= 3'd1) && (!alu_sub || alu_out)) else begin
         errors++;
         $error("FAIL %s bus got drivers=%0d sub=%0b want <=1 and sub only with alu_out",
                tag, drivers, alu_sub);
      end
   endtask

   task automatic step(input string tag, input logic [5:0] exp_t,
                       input logic [12:0] exp_c, input logic exp_h);
      @(posedge clk);
      #1;
      check_now(tag, exp_t, exp_c, exp_h);
   endtask

   // Run one full instruction from T1 through T6 and back to T1.
   task automatic instr(input string tag, input logic [3:0] op, input logic [12:0] w4,
                        input logic [12:0] w5, input logic [12:0] w6);
      opcode = op;
      step({tag, "_t2"}, 6'h02, W_T2, 1'b0);
      step({tag, "_t3"}, 6'h04, W_T3, 1'b0);
      step({tag, "_t4"}, 6'h08, w4, 1'b0);
      step({tag, "_t5"}, 6'h10, w5, 1'b0);
      step({tag, "_t6"}, 6'h20, w6, 1'b0);
      step({tag, "_t1"}, 6'h01, W_T1, 1'b0);
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 4'h0;
      step("rst1", 6'h01, W_T1, 1'b0);
      step("rst2", 6'h01, W_T1, 1'b0);
      reset = 1'b0;

      instr("lda", 4'h0, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_A_LOAD, C_NONE);
      instr("sub", 4'h2, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_B_LOAD,
            C_ALU_OUT | C_ALU_SUB | C_A_LOAD);
      instr("add", 4'h1, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_B_LOAD,
            C_ALU_OUT | C_A_LOAD);
      instr("out", 4'hE, C_A_OUT | C_OUT_LOAD, C_NONE, C_NONE);
      instr("nop7", 4'h7, C_NONE, C_NONE, C_NONE);
      instr("nopc", 4'hC, C_NONE, C_NONE, C_NONE);
`ifdef SAP_JMP_EN
      instr("jmp", 4'h6, C_IR_OUT | C_PC_LOAD, C_NONE, C_NONE);
`else
      instr("jmp", 4'h6, C_NONE, C_NONE, C_NONE);
`endif

      // HLT: T4 decodes no controls, then the machine parks in HALT.
      opcode = 4'hF;
      step("hlt_t2", 6'h02, W_T2, 1'b0);
      step("hlt_t3", 6'h04, W_T3, 1'b0);
      step("hlt_t4", 6'h08, C_NONE, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("halt%0d", i), 6'h00, C_NONE, 1'b1);
      end
      opcode = 4'h0;
      step("halt_hold", 6'h00, C_NONE, 1'b1);
      reset = 1'b1;
      step("halt_rst", 6'h01, W_T1, 1'b0);
      step("halt_rst2", 6'h01, W_T1, 1'b0);
      reset = 1'b0;
      step("halt_rel", 6'h02, W_T2, 1'b0);

      // Reset mid-instruction during ADD T5.
      opcode = 4'h1;
      step("mid_t3", 6'h04, W_T3, 1'b0);
      step("mid_t4", 6'h08, C_IR_OUT | C_MAR_LOAD, 1'b0);
      step("mid_t5", 6'h10, C_RAM_OUT | C_B_LOAD, 1'b0);
      reset = 1'b1;
      step("mid_rst", 6'h01, W_T1, 1'b0);
      reset = 1'b0;
      step("mid_rel", 6'h02, W_T2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
